test_pattern_gen: RTL and testbench

TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

---
 rtl/test_pattern_gen.sv | 131 +++++++++++++
 tb/tb_test_pattern_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_gen.sv
// Video test pattern generator: grid, colour bars, scrolling checker and bouncing box.
// Mode changes take effect only at frame_start; pixel output is registered with 1-cycle latency.
module test_pattern_gen #(
  parameter int HOR_ACTIVE_PIXELS = 1280,
  parameter int VER_ACTIVE_PIXELS = 720,
  parameter int CELL_SIZE         = 64,
  parameter int BOX_SIZE          = 64,
  parameter int SPEED             = 4,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  logic               de,
  input  logic               frame_start,
  input  logic [1:0]         mode_sel,
  input  logic               mode_load,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  output logic               de_out,
  output logic [7:0]         frame_cnt
);
  localparam int CB = $clog2(CELL_SIZE);
  localparam int PW = X_WIDTH + Y_WIDTH;
  localparam logic [31:0] SPD  = SPEED;
  localparam logic [31:0] XLIM = HOR_ACTIVE_PIXELS - BOX_SIZE;
  localparam logic [31:0] YLIM = VER_ACTIVE_PIXELS - BOX_SIZE;

  logic [1:0]         mode, pend;
  logic [X_WIDTH-1:0] box_x;
  logic [Y_WIDTH-1:0] box_y;
  logic               dir_x, dir_y;   // 1 = moving towards 0

  // next box position per axis, 32-bit so pos+SPEED cannot overflow
  logic [31:0] bx_w, by_w, nbx, nby;
  logic        ndx, ndy;
  always_comb begin
    bx_w = 32'(box_x);
    by_w = 32'(box_y);
    nbx = bx_w; ndx = dir_x;
    nby = by_w; ndy = dir_y;
    if (!dir_x) begin
      if (bx_w + SPD > XLIM) begin nbx = XLIM; ndx = 1'b1; end
      else nbx = bx_w + SPD;
    end else begin
      if (bx_w < SPD) begin nbx = '0; ndx = 1'b0; end
      else nbx = bx_w - SPD;
    end
    if (!dir_y) begin
      if (by_w + SPD > YLIM) begin nby = YLIM; ndy = 1'b1; end
      else nby = by_w + SPD;
    end else begin
      if (by_w < SPD) begin nby = '0; ndy = 1'b0; end
      else nby = by_w - SPD;
    end
  end

  logic [PW-1:0]      prod;
  logic [Y_WIDTH-1:0] diag;
  logic               grid_line;
  logic [X_WIDTH+2:0] x8;
  logic [2:0]         bar;
  logic [X_WIDTH:0]   xs, bx_end;
  logic [Y_WIDTH:0]   by_end;
  logic               chk, in_box;
  logic [23:0]        rgb;

  always_comb begin
    prod      = {{Y_WIDTH{1'b0}}, x} * PW'(VER_ACTIVE_PIXELS);
    diag      = Y_WIDTH'(prod / PW'(HOR_ACTIVE_PIXELS));
    grid_line = (x == '0) || (x == X_WIDTH'(HOR_ACTIVE_PIXELS - 1)) ||
                (y == '0) || (y == Y_WIDTH'(VER_ACTIVE_PIXELS - 1)) ||
                (y == diag) || (y == Y_WIDTH'(VER_ACTIVE_PIXELS - 1) - diag);
    x8     = {x, 3'b000};
    bar    = 3'(x8 / (X_WIDTH+3)'(HOR_ACTIVE_PIXELS));
    xs     = {1'b0, x} + (X_WIDTH+1)'(frame_cnt);
    chk    = xs[CB] ^ y[CB];
    bx_end = {1'b0, box_x} + (X_WIDTH+1)'(BOX_SIZE);
    by_end = {1'b0, box_y} + (Y_WIDTH+1)'(BOX_SIZE);
    in_box = (x >= box_x) && ({1'b0, x} < bx_end) &&
             (y >= box_y) && ({1'b0, y} < by_end);
    rgb = 24'h000000;
    case (mode)
      2'd0: rgb = grid_line ? 24'hFF0000 : 24'hFFFFFF;
      2'd1: begin
        case (bar)
          3'd0: rgb = 24'hFFFFFF;
          3'd1: rgb = 24'hFFFF00;
          3'd2: rgb = 24'h00FFFF;
          3'd3: rgb = 24'h00FF00;
          3'd4: rgb = 24'hFF00FF;
          3'd5: rgb = 24'hFF0000;
          3'd6: rgb = 24'h0000FF;
          default: rgb = 24'h000000;
        endcase
      end
      2'd2: rgb = chk ? 24'hFFFFFF : 24'h000000;
      default: rgb = in_box ? 24'h00FF00 : 24'h000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r, g, b} <= '0;
      de_out    <= 1'b0;
      frame_cnt <= '0;
      mode      <= '0;
      pend      <= '0;
      box_x     <= '0;
      box_y     <= '0;
      dir_x     <= 1'b0;
      dir_y     <= 1'b0;
    end else begin
      de_out    <= de;
      {r, g, b} <= de ? rgb : 24'h000000;
      if (mode_load) pend <= mode_sel;
      if (frame_start) begin
        // a load in the same cycle bypasses the pending register
        mode      <= mode_load ? mode_sel : pend;
        frame_cnt <= frame_cnt + 8'd1;
        box_x     <= X_WIDTH'(nbx);
        box_y     <= Y_WIDTH'(nby);
        dir_x     <= ndx;
        dir_y     <= ndy;
      end
    end
  end
endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: directed and random pixels against a plain-arithmetic colour model.
module tb_test_pattern_gen;
  localparam int H = 1280, V = 720, XW = 11, YW = 10, BOX = 64, SP = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [XW-1:0] x = '0;
  logic [YW-1:0] y = '0;
  logic          de = 1'b0, frame_start = 1'b0, mode_load = 1'b0;
  logic [1:0]    mode_sel = '0;
  logic [7:0]    r, g, b, frame_cnt;
  logic          de_out;

  test_pattern_gen dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .de(de), .frame_start(frame_start),
    .mode_sel(mode_sel), .mode_load(mode_load), .r(r), .g(g), .b(b),
    .de_out(de_out), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int m_pend, m_act, m_fc, m_bx, m_by, m_dx, m_dy;  // m_d* = +1 / -1

  function automatic logic [23:0] ref_rgb(int md, int px, int py);
    int d;
    case (md)
      0: begin
        d = (px * V) / H;
        return (px == 0 || px == H-1 || py == 0 || py == V-1 || py == d || py == V-1-d)
               ? 24'hFF0000 : 24'hFFFFFF;
      end
      1: case ((px * 8) / H)
        0: return 24'hFFFFFF;  1: return 24'hFFFF00;
        2: return 24'h00FFFF;  3: return 24'h00FF00;
        4: return 24'hFF00FF;  5: return 24'hFF0000;
        6: return 24'h0000FF;  default: return 24'h000000;
      endcase
      2: return (((((px + m_fc) / 64) % 2) ^ ((py / 64) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return (px >= m_bx && px < m_bx + BOX && py >= m_by && py < m_by + BOX)
                      ? 24'h00FF00 : 24'h000000;
    endcase
  endfunction

  function automatic int bounce_pos(int pos, int dir, int lim);
    if (dir > 0) return (pos + SP > lim - BOX) ? lim - BOX : pos + SP;
    return (pos < SP) ? 0 : pos - SP;
  endfunction

  function automatic int bounce_dir(int pos, int dir, int lim);
    if (dir > 0) return (pos + SP > lim - BOX) ? -1 : 1;
    return (pos < SP) ? 1 : -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_act = 0; m_fc = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("reset_out", {7'b0, de_out, r, g, b}, 32'h0);
    chk("reset_fcnt", {24'b0, frame_cnt}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // one active/blank pixel cycle, optionally with a mode_load strobe
  task automatic pix(input string tag, input int px, input int py, input bit d,
                     input bit ld = 1'b0, input int sel = 0);
    logic [23:0] e;
    x = XW'(px); y = YW'(py); de = d; frame_start = 1'b0;
    mode_load = ld; mode_sel = 2'(sel);
    @(posedge clk); #1;
    e = d ? ref_rgb(m_act, px, py) : 24'h0;
    chk(tag, {7'b0, de_out, r, g, b}, {7'b0, d, e});
    if (ld) m_pend = sel;
    mode_load = 1'b0; de = 1'b0;
  endtask

  task automatic fs(input bit ld = 1'b0, input int sel = 0);
    int nx, ny;
    de = 1'b0; frame_start = 1'b1; mode_load = ld; mode_sel = 2'(sel);
    @(posedge clk); #1;
    frame_start = 1'b0; mode_load = 1'b0;
    if (ld) m_pend = sel;
    m_act = m_pend;
    m_fc  = (m_fc + 1) % 256;
    nx = bounce_pos(m_bx, m_dx, H); m_dx = bounce_dir(m_bx, m_dx, H); m_bx = nx;
    ny = bounce_pos(m_by, m_dy, V); m_dy = bounce_dir(m_by, m_dy, V); m_by = ny;
    chk("fs_fcnt", {24'b0, frame_cnt}, 32'(m_fc));
    chk("fs_blank", {7'b0, de_out, r, g, b}, 32'h0);
  endtask

  initial begin
    int px, py, guard;
    model_reset();
    do_reset();

    // grid after reset
    pix("grid_0_5", 0, 5, 1);
    pix("grid_640_360", 640, 360, 1);
    pix("grid_100_300", 100, 300, 1);
    pix("blank_de0", 640, 360, 0);

    // mid-frame load must not change the pattern until frame_start
    pix("load1_still_grid", 10, 10, 1, 1'b1, 1);
    pix("grid_after_load", 100, 300, 1);
    fs();
    pix("bars_x0", 0, 100, 1);
    pix("bars_x1279", 1279, 100, 1);
    pix("bars_x160", 160, 100, 1);

    // last load wins; same-cycle load goes straight to active
    pix("load3", 5, 5, 1, 1'b1, 3);
    pix("load2", 700, 5, 1, 1'b1, 2);
    fs();
    pix("last_wins", 64, 0, 1);
    fs(1'b1, 1);
    pix("same_cycle_load", 500, 200, 1);

    // random pixels in every mode, with occasional frame_starts
    for (int md = 0; md < 4; md++) begin
      fs(1'b1, md);
      for (int i = 0; i < 80; i++) begin
        px = $urandom_range(H-1);
        py = $urandom_range(V-1);
        if (md == 0 && i % 4 == 0) py = (px * V) / H;
        if (md == 3 && i % 3 == 0) begin
          px = m_bx + $urandom_range(BOX) - 1;
          py = m_by + $urandom_range(BOX) - 1;
          if (px < 0) px = 0;
          if (py < 0) py = 0;
        end
        pix("rand_pix", px, py, 1'($urandom_range(3) != 0));
        if (i % 16 == 15) fs();
      end
    end

    // scrolling checker at frame_cnt 0 and 64
    fs(1'b1, 2);
    guard = 0;
    while (m_fc != 0 && guard < 300) begin fs(); guard++; end
    pix("chk_fc0_0_0", 0, 0, 1);
    pix("chk_fc0_64_0", 64, 0, 1);
    repeat (64) fs();
    pix("chk_fc64_0_0", 0, 0, 1);

    // bouncing box over 400 frames from reset
    do_reset();
    fs(1'b1, 3);
    repeat (399) begin
      fs();
      pix("box_corner", m_bx, m_by, 1);
      pix("box_right", m_bx + BOX, m_by, 1);
    end
    pix("box_inner_last", m_bx + BOX - 1, m_by + BOX - 1, 1);

    // async reset mid-frame with de=1, pending load discarded
    fs(1'b1, 0);
    pix("pre_rst_red", 0, 5, 1, 1'b1, 3);
    x = '0; y = YW'(5); de = 1'b1;
    #3 rst_n = 1'b0;
    #1 chk("async_rst_out", {7'b0, de_out, r, g, b}, 32'h0);
    chk("async_rst_fcnt", {24'b0, frame_cnt}, 32'h0);
    de = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    fs();
    pix("discard_pending", 100, 300, 1);
    fs(1'b1, 3);
    pix("box_8_8", 8, 8, 1);
    pix("box_7_8", 7, 8, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
